// File: rtl/seq_addsub32_if.sv
// Start/done handshake bundle for the sequential adder/subtractor.
// A controller drives the master side and the datapath block sits on the slave side.
interface seq_addsub32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             overflow;
    logic             carry_out;

    // Handshake: start is sampled only while busy=0. Any start seen while busy=1
    // is dropped. done is a one-cycle pulse, and z/overflow/carry_out hold their
    // values from that pulse until the next completion or reset.
    modport master (
        output start, op, x, y,
        input  busy, done, z, overflow, carry_out
    );

    modport slave (
        input  start, op, x, y,
        output busy, done, z, overflow, carry_out
    );
endinterface

// File: rtl/seq_addsub32.sv
// Digit-serial two's-complement adder/subtractor. Each RUN cycle it takes one
// DIGIT-wide slice, starting at the LSB. A subtract adds ~y plus an initial carry of 1.
module seq_addsub32 #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    seq_addsub32_if.slave  bus,
    output logic           dbg_run
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             load, step, last;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, a_msb_q, b_msb_q;
    logic [DIGIT:0]   sum_w;
    logic [WIDTH-1:0] z_q;
    logic             ovf_q, cout_q, done_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sum_w    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // Each new slice enters at the MSB end. After N shifts the first slice has reached bit 0.
    assign res_next = {sum_w[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            z_q     <= '0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (load) begin
                a_q     <= bus.x;
                b_q     <= bus.y ^ {WIDTH{bus.op}};
                a_msb_q <= bus.x[WIDTH-1];
                b_msb_q <= bus.y[WIDTH-1] ^ bus.op;
                carry_q <= bus.op;
                res_q   <= '0;
                cnt_q   <= '0;
            end else if (step) begin
                a_q     <= a_q >> DIGIT;
                b_q     <= b_q >> DIGIT;
                res_q   <= res_next;
                carry_q <= sum_w[DIGIT];
                cnt_q   <= cnt_q + CW'(1);
            end
            if (last) begin
                z_q    <= res_next;
                cout_q <= sum_w[DIGIT];
                ovf_q  <= (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
            end
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.z         = z_q;
    assign bus.overflow  = ovf_q;
    assign bus.carry_out = cout_q;
    assign dbg_run       = (state_q == RUN);
endmodule

// File: tb/tb_seq_addsub32.sv
// Directed bench for seq_addsub32. The expected values below were worked out by hand
// for each vector, and every comparison goes through an immediate assertion.
module tb_seq_addsub32;
  logic clk;
  logic rst;
  logic dbg_run;
  int   checks;
  int   errors;
  int   lat;
  int   zchg;
  int   extra;

  seq_addsub32_if #(.WIDTH(32)) bus ();

  seq_addsub32 #(.WIDTH(32), .DIGIT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .dbg_run (dbg_run)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive start for one edge (E0); returns just after E0
  task automatic issue(input logic op, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = op;
    bus.x     = x;
    bus.y     = y;
    tick();
    bus.start = 1'b0;
    bus.x     = $urandom;
    bus.y     = $urandom;
    bus.op    = 1'($urandom_range(0, 1));
  endtask

  // counts edges until done is seen, and counts cycles where z moved before done
  task automatic wait_done(input int pre, output int latency, output int zmoves);
    logic [31:0] zref;
    zref    = bus.z;
    latency = pre;
    zmoves  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      latency++;
      if (bus.done) break;
      if (bus.z !== zref) zmoves++;
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done) n++;
    end
  endtask

  task automatic run_check(input string tag, input logic op, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] ez,
                           input logic eovf, input logic ecout);
    issue(op, x, y);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(0, lat, zchg);
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_zhold"}, 32'(zchg), 32'd0);
    chk({tag, "_z"}, bus.z, ez);
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(eovf));
    chk({tag, "_cout"}, 32'(bus.carry_out), 32'(ecout));
    chk({tag, "_dbusy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_z", bus.z, 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_cout", 32'(bus.carry_out), 32'd0);
    chk("rst_state", 32'(dbg_run), 32'd0);

    // sub with a negative minuend
    run_check("sub_neg", 1'b1, 32'h8000_0001, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    tick();
    chk("sub_neg_pulse", 32'(bus.done), 32'd0);
    chk("sub_neg_zkeep", bus.z, 32'h8000_0000);

    run_check("sub_ovf", 1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_check("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0);
    run_check("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b0, 1'b1);
    run_check("sub_borrow", 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_check("add_mix", 1'b0, 32'hA5A5_0F0F, 32'h5A5A_F0F1, 32'h0000_0000, 1'b0, 1'b1);

    // start while busy is ignored
    issue(1'b1, 32'h8000_0001, 32'd1);
    tick();
    tick();
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.x     = 32'd1;
    bus.y     = 32'd1;
    tick();
    bus.start = 1'b0;
    wait_done(3, lat, zchg);
    chk("ign_lat", 32'(lat), 32'd8);
    chk("ign_z", bus.z, 32'h8000_0000);
    chk("ign_cout", 32'(bus.carry_out), 32'd1);
    count_done(14, extra);
    chk("ign_single", 32'(extra), 32'd0);

    // back-to-back: start accepted in the done cycle
    issue(1'b0, 32'd1, 32'd1);
    wait_done(0, lat, zchg);
    chk("b2b_first_z", bus.z, 32'd2);
    chk("b2b_first_done", 32'(bus.done), 32'd1);
    issue(1'b0, 32'h1234_5678, 32'h1111_1111);
    chk("b2b_done_fall", 32'(bus.done), 32'd0);
    chk("b2b_busy_rise", 32'(bus.busy), 32'd1);
    chk("b2b_zheld", bus.z, 32'd2);
    wait_done(0, lat, zchg);
    chk("b2b_lat", 32'(lat), 32'd8);
    chk("b2b_zhold", 32'(zchg), 32'd0);
    chk("b2b_z", bus.z, 32'h2345_6789);
    chk("b2b_ovf", 32'(bus.overflow), 32'd0);
    chk("b2b_cout", 32'(bus.carry_out), 32'd0);

    // abort mid-run with nonzero outputs present
    run_check("pre_abort", 1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    issue(1'b1, 32'd9, 32'd3);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_z", bus.z, 32'd0);
    chk("abort_ovf", 32'(bus.overflow), 32'd0);
    chk("abort_cout", 32'(bus.carry_out), 32'd0);
    count_done(14, extra);
    chk("abort_nodone", 32'(extra), 32'd0);

    // rst beats start in the same cycle
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("rst_win_busy", 32'(bus.busy), 32'd0);
    count_done(12, extra);
    chk("rst_win_nodone", 32'(extra), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
